// File: rtl/rf_wb_scheduler.sv
// Write-back scheduler: round-robin arbitration of write-back sources onto the
// single register-file write port, plus a busy-register scoreboard for RAW hazards.
module rf_wb_scheduler #(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = 32,
  parameter int AW      = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*AW-1:0]   req_rd,
  input  logic [NUM_REQ*XLEN-1:0] req_data,
  output logic                    rf_wr_en,
  output logic [AW-1:0]           rf_rd,
  output logic [XLEN-1:0]         rf_data,
  input  logic                    rsv_valid,
  input  logic [AW-1:0]           rsv_rd,
  input  logic                    flush,
  input  logic [AW-1:0]           chk_rs1,
  input  logic [AW-1:0]           chk_rs2,
  output logic                    hazard,
  output logic [2**AW-1:0]        busy_mask
);

  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0]      ptr;
  logic [PW-1:0]      grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic               found;
  logic               accept;
  int                 scan_idx;
  logic [AW-1:0]      grant_rd;
  logic [XLEN-1:0]    grant_data;
  logic [2**AW-1:0]   busy_next;

  // Handshake: a transfer happens on a rising edge where req_valid[i] & req_ready[i].
  // Ready depends on valid, so requesters hold valid/rd/data until accepted and
  // never derive valid from ready.
  always_comb begin
    grant     = '0;
    grant_idx = ptr;
    found     = 1'b0;
    scan_idx  = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      scan_idx = (int'(ptr) + off) % NUM_REQ;
      if (!found && req_valid[scan_idx]) begin
        found            = 1'b1;
        grant[scan_idx]  = 1'b1;
        grant_idx        = PW'(scan_idx);
      end
    end
  end

  assign req_ready  = grant;
  assign accept     = found;
  assign grant_rd   = req_rd[int'(grant_idx)*AW +: AW];
  assign grant_data = req_data[int'(grant_idx)*XLEN +: XLEN];

  // Newer reservation beats the commit clear; flush beats everything; r0 never busy.
  always_comb begin
    busy_next = busy_mask;
    if (rf_wr_en) busy_next[rf_rd] = 1'b0;
    if (rsv_valid && rsv_rd != '0) busy_next[rsv_rd] = 1'b1;
    if (flush) busy_next = '0;
    busy_next[0] = 1'b0;
  end

  assign hazard = busy_mask[chk_rs1] | busy_mask[chk_rs2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= PW'(NUM_REQ - 1);
      rf_wr_en  <= 1'b0;
      rf_rd     <= '0;
      rf_data   <= '0;
      busy_mask <= '0;
    end else begin
      busy_mask <= busy_next;
      rf_wr_en  <= 1'b0;
      if (accept) begin
        ptr <= grant_idx;
        // Writes to r0 are consumed but never reach the register file.
        if (grant_rd != '0) begin
          rf_wr_en <= 1'b1;
          rf_rd    <= grant_rd;
          rf_data  <= grant_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed bench for rf_wb_scheduler: arbitration order, write latency, r0 handling,
// scoreboard set/clear/flush precedence and asynchronous reset.
module tb_rf_wb_scheduler;

  localparam int NUM_REQ = 2;
  localparam int XLEN    = 32;
  localparam int AW      = 5;

  logic                    clk;
  logic                    rst_n;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [AW-1:0]           rd0, rd1;
  logic [XLEN-1:0]         data0, data1;
  logic [NUM_REQ*AW-1:0]   req_rd;
  logic [NUM_REQ*XLEN-1:0] req_data;
  logic                    rf_wr_en;
  logic [AW-1:0]           rf_rd;
  logic [XLEN-1:0]         rf_data;
  logic                    rsv_valid;
  logic [AW-1:0]           rsv_rd;
  logic                    flush;
  logic [AW-1:0]           chk_rs1, chk_rs2;
  logic                    hazard;
  logic [2**AW-1:0]        busy_mask;

  int checks = 0;
  int errors = 0;

  assign req_rd   = {rd1, rd0};
  assign req_data = {data1, data0};

  rf_wb_scheduler #(.NUM_REQ(NUM_REQ), .XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rd(req_rd), .req_data(req_data),
    .rf_wr_en(rf_wr_en), .rf_rd(rf_rd), .rf_data(rf_data),
    .rsv_valid(rsv_valid), .rsv_rd(rsv_rd), .flush(flush),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
    .hazard(hazard), .busy_mask(busy_mask)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // advance one rising edge, then settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; rd0 = '0; rd1 = '0; data0 = '0; data1 = '0;
    rsv_valid = 1'b0; rsv_rd = '0; flush = 1'b0; chk_rs1 = '0; chk_rs2 = '0;
    #1;
    chk("reset_wr_en", rf_wr_en, 0);
    chk("reset_rd", rf_rd, 0);
    chk("reset_data", rf_data, 0);
    chk("reset_busy", busy_mask, 0);
    chk("reset_hazard", hazard, 0);
    step(); step();
    #2 rst_n = 1'b1;
    step();

    // 1: both valid, requester 0 first, latency 1
    req_valid = 2'b11; rd0 = 5'd3; data0 = 32'hAAAA0001; rd1 = 5'd4; data1 = 32'hBBBB0002;
    #1;
    chk("t1_c0_ready", req_ready, 2'b01);
    chk("t1_c0_wr_en", rf_wr_en, 0);
    step();
    chk("t1_c1_wr_en", rf_wr_en, 1);
    chk("t1_c1_rd", rf_rd, 3);
    chk("t1_c1_data", rf_data, 32'hAAAA0001);
    chk("t1_c1_ready", req_ready, 2'b10);
    step();
    chk("t1_c2_rd", rf_rd, 4);
    chk("t1_c2_data", rf_data, 32'hBBBB0002);
    req_valid = 2'b00;
    step();
    chk("t1_idle_wr_en", rf_wr_en, 0);
    chk("t1_idle_rd_hold", rf_rd, 4);
    chk("t1_idle_data_hold", rf_data, 32'hBBBB0002);

    // 2: alternation, then a lone requester keeps winning
    req_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("t2_alt_ready_%0d", i), req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      step();
      chk($sformatf("t2_alt_rd_%0d", i), rf_rd, (i % 2 == 0) ? 3 : 4);
    end
    req_valid = 2'b10;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("t2_solo1_ready_%0d", i), req_ready, 2'b10);
      step();
      chk($sformatf("t2_solo1_wr_en_%0d", i), rf_wr_en, 1);
    end
    req_valid = 2'b01;
    #1;
    chk("t2_solo0_ready", req_ready, 2'b01);
    step();
    chk("t2_solo0_rd", rf_rd, 3);
    req_valid = 2'b00;
    step();

    // 3: write to r0 is accepted but not performed
    req_valid = 2'b01; rd0 = 5'd0; data0 = 32'h0000DEAD;
    #1;
    chk("t3_ready", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    chk("t3_wr_en", rf_wr_en, 0);
    chk("t3_busy", busy_mask, 0);
    #1;
    chk("t3_ptr_advanced", req_ready, 2'b00);
    req_valid = 2'b11; rd0 = 5'd0; rd1 = 5'd0;
    #1;
    chk("t3_next_grant", req_ready, 2'b10);
    req_valid = 2'b00;
    step();

    // 4: reserve r5, hazard until the cycle after commit
    rsv_valid = 1'b1; rsv_rd = 5'd5; chk_rs1 = 5'd5; chk_rs2 = 5'd0;
    #1;
    chk("t4_hazard_before", hazard, 0);
    step();
    rsv_valid = 1'b0;
    chk("t4_hazard_set", hazard, 1);
    chk("t4_busy_set", busy_mask, 32'h0000_0020);
    req_valid = 2'b01; rd0 = 5'd5; data0 = 32'h0000_0055;
    #1;
    chk("t4_ready", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    chk("t4_commit_wr_en", rf_wr_en, 1);
    chk("t4_commit_rd", rf_rd, 5);
    chk("t4_hazard_commit", hazard, 1);
    step();
    chk("t4_hazard_clear", hazard, 0);
    chk("t4_busy_clear", busy_mask, 0);

    // 5: reserve wins over same-edge clear, then flush
    rsv_valid = 1'b1; rsv_rd = 5'd7; chk_rs1 = 5'd0; chk_rs2 = 5'd7;
    step();
    rsv_valid = 1'b0;
    chk("t5_busy7", busy_mask, 32'h0000_0080);
    chk("t5_hazard_rs2", hazard, 1);
    req_valid = 2'b01; rd0 = 5'd7; data0 = 32'h0000_0077;
    step();
    req_valid = 2'b00;
    chk("t5_commit_wr_en", rf_wr_en, 1);
    chk("t5_commit_rd", rf_rd, 7);
    rsv_valid = 1'b1; rsv_rd = 5'd7;
    step();
    rsv_valid = 1'b0;
    chk("t5_set_wins", busy_mask, 32'h0000_0080);
    req_valid = 2'b01; rd0 = 5'd6; data0 = 32'h0000_0066;
    flush = 1'b1; rsv_valid = 1'b1; rsv_rd = 5'd2;
    #1;
    chk("t5_flush_ready", req_ready, 2'b01);
    step();
    flush = 1'b0; rsv_valid = 1'b0; req_valid = 2'b00;
    chk("t5_flush_busy", busy_mask, 0);
    chk("t5_flush_wr_en", rf_wr_en, 1);
    chk("t5_flush_rd", rf_rd, 6);
    chk("t5_flush_data", rf_data, 32'h0000_0066);
    step();

    // 6: asynchronous reset mid-traffic
    rsv_valid = 1'b1; rsv_rd = 5'd3;
    step();
    rsv_rd = 5'd5;
    req_valid = 2'b10; rd1 = 5'd2; data1 = 32'h0000_0022;
    step();
    rsv_valid = 1'b0;
    chk("t6_busy_pre", busy_mask, 32'h0000_0028);
    chk("t6_wr_en_pre", rf_wr_en, 1);
    req_valid = 2'b11; rd0 = 5'd1; data0 = 32'h0000_0011;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_wr_en", rf_wr_en, 0);
    chk("t6_rst_rd", rf_rd, 0);
    chk("t6_rst_data", rf_data, 0);
    chk("t6_rst_busy", busy_mask, 0);
    chk("t6_rst_ready", req_ready, 2'b01);
    rst_n = 1'b1;
    step();
    chk("t6_post_wr_en", rf_wr_en, 1);
    chk("t6_post_rd", rf_rd, 1);
    chk("t6_post_data", rf_data, 32'h0000_0011);
    req_valid = 2'b00;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
